// File: rtl/mtr_pkg.sv
// Shared definitions for the motor ramp driver.
// The package holds the duty width, the mid-scale (zero-torque) duty, the last
// counter value of a PWM period, the non-overlap channel state type and two
// helpers: speed-to-duty conversion and the per-period slew step.
package mtr_pkg;

  localparam int               PWM_W      = 11;
  localparam logic [PWM_W-1:0] DUTY_MID   = 11'h400;
  localparam logic [PWM_W-1:0] PERIOD_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    LO_WAIT,
    LO,
    HI_WAIT,
    HI
  } nonovl_state_t;

  // Signed speed to offset-binary duty: adding mid-scale modulo 2^11 maps
  // -1024 -> 0, 0 -> 1024, 1023 -> 2047.
  function automatic logic [PWM_W-1:0] spd_to_duty(input logic [PWM_W-1:0] spd);
    return spd + DUTY_MID;
  endfunction

  // Move cur toward tgt by at most step. Comparisons are done one bit wider
  // so that neither cur+step nor tgt+step can wrap; the final 11-bit add or
  // subtract is only taken when it is known to stay in range.
  function automatic logic [PWM_W-1:0] slew_step(
    input logic [PWM_W-1:0] cur,
    input logic [PWM_W-1:0] tgt,
    input logic [PWM_W-1:0] step
  );
    logic [PWM_W:0] cur_w;
    logic [PWM_W:0] tgt_w;
    logic [PWM_W:0] step_w;
    cur_w  = {1'b0, cur};
    tgt_w  = {1'b0, tgt};
    step_w = {1'b0, step};
    if (tgt_w > cur_w) begin
      if (cur_w + step_w >= tgt_w) return tgt;
      else                         return cur + step;
    end else if (tgt_w < cur_w) begin
      if (tgt_w + step_w >= cur_w) return tgt;
      else                         return cur - step;
    end
    return cur;
  endfunction

endpackage

// File: rtl/pwm_nonovl_ch.sv
// One complementary PWM channel with non-overlap deadtime.
// The raw level (cnt < duty) drives a four-state FSM; every raw-level change
// passes through a wait state where both outputs are low for NONOVERLAP clks
// before the new side is driven. Raw pulses shorter than the deadtime never
// reach either output. en low forces the channel back to LO_WAIT (coast).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        drive enable; low = both outputs low next clk
//   cnt_i       period counter
//   duty_i      applied duty
//   pwm1_o      high-side drive (registered, state == HI)
//   pwm2_o      low-side drive  (registered, state == LO)
module pwm_nonovl_ch
  import mtr_pkg::*;
#(
  parameter int NONOVERLAP = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic [PWM_W-1:0] duty_i,
  output logic             pwm1_o,
  output logic             pwm2_o
);

  localparam logic [7:0] DT_LAST = 8'(NONOVERLAP - 1);

  nonovl_state_t state_q, state_d;
  logic [7:0]    dt_cnt_q, dt_cnt_d;
  logic          pwm1_q, pwm2_q;
  logic          raw;

  assign raw = (cnt_i < duty_i);

  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!en_i) begin
      state_d  = LO_WAIT;
      dt_cnt_d = '0;
    end else begin
      case (state_q)
        LO_WAIT: begin
          if (raw) begin
            state_d  = HI_WAIT;
            dt_cnt_d = '0;
          end else if (dt_cnt_q == DT_LAST) begin
            state_d = LO;
          end else begin
            dt_cnt_d = dt_cnt_q + 8'd1;
          end
        end
        LO: begin
          if (raw) begin
            state_d  = HI_WAIT;
            dt_cnt_d = '0;
          end
        end
        HI_WAIT: begin
          if (!raw) begin
            state_d  = LO_WAIT;
            dt_cnt_d = '0;
          end else if (dt_cnt_q == DT_LAST) begin
            state_d = HI;
          end else begin
            dt_cnt_d = dt_cnt_q + 8'd1;
          end
        end
        HI: begin
          if (!raw) begin
            state_d  = LO_WAIT;
            dt_cnt_d = '0;
          end
        end
        default: begin
          state_d  = LO_WAIT;
          dt_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LO_WAIT;
      dt_cnt_q <= '0;
      pwm1_q   <= 1'b0;
      pwm2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      pwm1_q   <= (state_d == HI);
      pwm2_q   <= (state_d == LO);
    end
  end

  assign pwm1_o = pwm1_q;
  assign pwm2_o = pwm2_q;

endmodule

// File: rtl/mtr_ramp_drv.sv
// Motor ramp driver: turns the heading controller's signed left/right speeds
// into slew-limited offset-binary duties and complementary H-bridge PWM.
// A free-running 11-bit counter defines a 2048-clk PWM period. On the last
// count of each period both duties step toward their targets by at most
// MAX_STEP; the new duties apply from count 0, flagged by duty_upd.
// duty_upd is a one-cycle strobe with no back-pressure: a consumer that wants
// the new duties must sample lft_duty/rght_duty in the cycle it is high.
// en low coasts: next clk all drives low, duties back to mid-scale, limiter
// frozen; en low takes priority over a period-boundary update.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  drive enable (low = coast)
//   lft_spd, rght_spd   signed speeds, -1024..1023
//   lftPWM1/lftPWM2     left high-/low-side drive
//   rghtPWM1/rghtPWM2   right high-/low-side drive
//   lft_duty, rght_duty currently applied duties
//   duty_upd            strobe while count == 0 after an update
module mtr_ramp_drv
  import mtr_pkg::*;
#(
  parameter int NONOVERLAP = 32,
  parameter int MAX_STEP   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [PWM_W-1:0] lft_spd,
  input  logic signed [PWM_W-1:0] rght_spd,
  output logic                    lftPWM1,
  output logic                    lftPWM2,
  output logic                    rghtPWM1,
  output logic                    rghtPWM2,
  output logic        [PWM_W-1:0] lft_duty,
  output logic        [PWM_W-1:0] rght_duty,
  output logic                    duty_upd
);

  localparam logic [PWM_W-1:0] STEP = PWM_W'(MAX_STEP);

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] lft_duty_q, lft_duty_d;
  logic [PWM_W-1:0] rght_duty_q, rght_duty_d;
  logic             duty_upd_q, duty_upd_d;
  logic             period_end;

  assign period_end = (cnt_q == PERIOD_MAX);

  always_comb begin
    lft_duty_d  = lft_duty_q;
    rght_duty_d = rght_duty_q;
    duty_upd_d  = 1'b0;
    if (!en) begin
      lft_duty_d  = DUTY_MID;
      rght_duty_d = DUTY_MID;
    end else if (period_end) begin
      lft_duty_d  = slew_step(lft_duty_q,  spd_to_duty(lft_spd),  STEP);
      rght_duty_d = slew_step(rght_duty_q, spd_to_duty(rght_spd), STEP);
      duty_upd_d  = 1'b1;
    end
  end

  // The period counter ignores en so PWM phase stays fixed across coasting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      lft_duty_q  <= DUTY_MID;
      rght_duty_q <= DUTY_MID;
      duty_upd_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_q + 1'b1;
      lft_duty_q  <= lft_duty_d;
      rght_duty_q <= rght_duty_d;
      duty_upd_q  <= duty_upd_d;
    end
  end

  pwm_nonovl_ch #(.NONOVERLAP(NONOVERLAP)) u_lft_ch (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .cnt_i  (cnt_q),
    .duty_i (lft_duty_q),
    .pwm1_o (lftPWM1),
    .pwm2_o (lftPWM2)
  );

  pwm_nonovl_ch #(.NONOVERLAP(NONOVERLAP)) u_rght_ch (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .cnt_i  (cnt_q),
    .duty_i (rght_duty_q),
    .pwm1_o (rghtPWM1),
    .pwm2_o (rghtPWM2)
  );

  assign lft_duty  = lft_duty_q;
  assign rght_duty = rght_duty_q;
  assign duty_upd  = duty_upd_q;

endmodule

// File: tb/tb_mtr_ramp_drv.sv
module tb_mtr_ramp_drv;

  localparam int NONOVERLAP = 32;
  localparam int MAX_STEP   = 128;
  localparam int PERIOD     = 2048;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic               en       = 1'b0;
  logic signed [10:0] lft_spd  = '0;
  logic signed [10:0] rght_spd = '0;
  logic               lftPWM1, lftPWM2, rghtPWM1, rghtPWM2;
  logic        [10:0] lft_duty, rght_duty;
  logic               duty_upd;

  mtr_ramp_drv #(.NONOVERLAP(NONOVERLAP), .MAX_STEP(MAX_STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .lftPWM1   (lftPWM1),
    .lftPWM2   (lftPWM2),
    .rghtPWM1  (rghtPWM1),
    .rghtPWM2  (rghtPWM2),
    .lft_duty  (lft_duty),
    .rght_duty (rght_duty),
    .duty_upd  (duty_upd)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [21:0] exp_q[$];

  task automatic check_eq(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_cmp++;
    if (act < lim) begin
      n_err++;
      $display("FAIL %s: got %0d required >= %0d at %0t", name, act, lim, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Period position, applied duties and how many consecutive boundaries each
  // duty has stayed unchanged with the drive enabled.
  int m_cnt  = 0;
  int m_lft  = 1024;
  int m_rght = 1024;
  int stab_l = 0;
  int stab_r = 0;
  int nl, nr;

  function automatic int slew_ref(input int cur, input int tgt);
    if (tgt > cur) return (tgt < cur + MAX_STEP) ? tgt : cur + MAX_STEP;
    if (tgt < cur) return (tgt > cur - MAX_STEP) ? tgt : cur - MAX_STEP;
    return cur;
  endfunction

  function automatic int tgt_of(input logic signed [10:0] s);
    return int'(s) + 1024;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_lft  = 1024;
      m_rght = 1024;
      stab_l = 0;
      stab_r = 0;
      exp_q.delete();
    end else begin
      if (!en) begin
        m_lft  = 1024;
        m_rght = 1024;
        stab_l = 0;
        stab_r = 0;
      end else if (m_cnt == PERIOD - 1) begin
        nl = slew_ref(m_lft, tgt_of(lft_spd));
        nr = slew_ref(m_rght, tgt_of(rght_spd));
        stab_l = (nl == m_lft) ? stab_l + 1 : 0;
        stab_r = (nr == m_rght) ? stab_r + 1 : 0;
        m_lft  = nl;
        m_rght = nr;
        exp_q.push_back({11'(nl), 11'(nr)});
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  // ---------------- monitor ----------------
  string       nm[2] = '{"lft", "rght"};
  int          cyc   = 0;
  logic        ca[2], cb[2];
  logic        pa[2] = '{1'b0, 1'b0};
  logic        pb[2] = '{1'b0, 1'b0};
  int          fa[2] = '{0, 0};
  int          fb[2] = '{0, 0};
  int          ona[2] = '{0, 0};
  int          onb[2] = '{0, 0};
  int          d_ref, s_ref, exa, exb;
  logic [21:0] e_pop;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        pa[c] = 1'b0; pb[c] = 1'b0;
        fa[c] = cyc;  fb[c] = cyc;
        ona[c] = 0;   onb[c] = 0;
      end
    end else begin
      cyc++;
      if (duty_upd) begin
        if (exp_q.size() == 0) begin
          check_eq("duty_upd_unexpected", 1, 0);
        end else begin
          e_pop = exp_q.pop_front();
          check_eq("upd_lft_duty", int'(lft_duty), int'(e_pop[21:11]));
          check_eq("upd_rght_duty", int'(rght_duty), int'(e_pop[10:0]));
        end
      end
      if (exp_q.size() != 0) begin
        check_eq("duty_upd_missing", 0, 1);
        exp_q.delete();
      end
      ca[0] = lftPWM1;  cb[0] = lftPWM2;
      ca[1] = rghtPWM1; cb[1] = rghtPWM2;
      for (int c = 0; c < 2; c++) begin
        check_eq({"both_hi_", nm[c]}, int'(ca[c] & cb[c]), 0);
        if (pa[c] && !ca[c]) fa[c] = cyc;
        if (pb[c] && !cb[c]) fb[c] = cyc;
        if (!pa[c] && ca[c]) check_ge({"deadtime_pwm1_", nm[c]}, cyc - fb[c], NONOVERLAP);
        if (!pb[c] && cb[c]) check_ge({"deadtime_pwm2_", nm[c]}, cyc - fa[c], NONOVERLAP);
        pa[c] = ca[c];
        pb[c] = cb[c];
        ona[c] += int'(ca[c]);
        onb[c] += int'(cb[c]);
        if (m_cnt == PERIOD - 1) begin
          d_ref = (c == 0) ? m_lft : m_rght;
          s_ref = (c == 0) ? stab_l : stab_r;
          if (s_ref >= 2) begin
            if (d_ref == 0) begin
              exa = 0;
              exb = PERIOD;
            end else begin
              exa = (d_ref > NONOVERLAP) ? d_ref - NONOVERLAP : 0;
              exb = (PERIOD - d_ref > NONOVERLAP) ? PERIOD - d_ref - NONOVERLAP : 0;
            end
            check_eq({"pwm1_on_time_", nm[c]}, ona[c], exa);
            check_eq({"pwm2_on_time_", nm[c]}, onb[c], exb);
          end
          ona[c] = 0;
          onb[c] = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_cnt(input int off);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 2 * PERIOD && !hit; k++) begin
      @(negedge clk);
      if (m_cnt == off) hit = 1'b1;
    end
    check_eq("at_cnt_reached", int'(hit), 1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_lft_duty"}, int'(lft_duty), 'h400);
    check_eq({tag, "_rght_duty"}, int'(rght_duty), 'h400);
    check_eq({tag, "_lftPWM1"}, int'(lftPWM1), 0);
    check_eq({tag, "_lftPWM2"}, int'(lftPWM2), 0);
    check_eq({tag, "_rghtPWM1"}, int'(rghtPWM1), 0);
    check_eq({tag, "_rghtPWM2"}, int'(rghtPWM2), 0);
    check_eq({tag, "_duty_upd"}, int'(duty_upd), 0);
  endtask

  // ---------------- stimulus ----------------
  bit ok;
  int r;

  initial begin
    #1 rst_n = 1'b0;
    #1 check_idle("reset");
    en       = 1'b1;
    lft_spd  = 11'sd0;
    rght_spd = -11'sd1024;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Mid-scale steady state, then left ramp to +512 while right falls to 0.
    wait_cycles(3 * PERIOD);
    at_cnt(700);
    lft_spd = 11'sd512;
    wait_cycles(8 * PERIOD);

    // Coast while left high side is on, then restart the ramps from mid-scale.
    ok = 1'b0;
    for (int k = 0; k < 3 * PERIOD && !ok; k++) begin
      @(negedge clk);
      if (lftPWM1 && lft_duty == 11'h600) ok = 1'b1;
    end
    check_eq("wait_lft_hi_at_600", int'(ok), 1);
    en       = 1'b0;
    rght_spd = 11'sd1023;
    @(negedge clk);
    check_idle("coast");
    wait_cycles(5);
    en = 1'b1;
    wait_cycles(6 * PERIOD);
    lft_spd = 11'sd0;
    wait_cycles(5 * PERIOD);

    // Random speed and enable traffic.
    for (int k = 0; k < 10; k++) begin
      wait_cycles($urandom_range(50, 1500));
      r = $urandom_range(0, 5);
      if (r == 0) begin
        en = 1'b0;
        wait_cycles($urandom_range(1, 40));
        en = 1'b1;
      end else if (r < 3) begin
        lft_spd = 11'($urandom_range(0, 2047));
      end else begin
        rght_spd = 11'($urandom_range(0, 2047));
      end
    end

    // Asynchronous reset in the middle of a period with left duty at 0x500.
    en      = 1'b1;
    lft_spd = 11'sd256;
    ok = 1'b0;
    for (int k = 0; k < 12 * PERIOD && !ok; k++) begin
      @(negedge clk);
      if (lft_duty == 11'h500) ok = 1'b1;
    end
    check_eq("wait_lft_duty_500", int'(ok), 1);
    wait_cycles($urandom_range(100, 1500));
    #3 rst_n = 1'b0;
    #1 check_idle("mid_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cycles(2 * PERIOD + 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
